// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage between execute and writeback; issues one dmem request
// per memory op and waits for dmem_ready under a timeout. Build macro: LSU_MISALIGN_TRAP_EN.
module lsu_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] Rd2_exe2lsu,
    input  logic [1:0]       Memtoreg_exe2lsu,
    input  logic [2:0]       Ld_cntr_exe2lsu,
    input  logic [1:0]       St_cntr_exe2lsu,
    input  logic             RegW_exe2lsu,
    input  logic [4:0]       wr_addr_exe2lsu,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_regw,
    output logic [4:0]       wb_addr,
    output logic             lsu_stall,
    output logic             bus_err,
    output logic             misalign
);
    // dmem handshake: dmem_req and its addr/we/be/wdata stay frozen from issue until the
    // first edge that samples dmem_ready=1; that edge completes the transfer and drops req.
    // dmem_ready outside WAIT carries no meaning and is ignored.
    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_n;
    logic [7:0]       wait_cnt;
    logic             is_load, mem_op, is_byte, is_half, is_word, trap, timeout_hit;
    logic [1:0]       off;
    logic [3:0]       be;
    logic [WIDTH-1:0] wdata, load_val;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;

    logic [2:0]       lat_ld;
    logic [1:0]       lat_off, lat_mtr;
    logic             lat_regw, lat_load;
    logic [4:0]       lat_wr;
    logic [WIDTH-1:0] lat_addr;

    always_comb begin
        is_load = (Ld_cntr_exe2lsu >= 3'b001) && (Ld_cntr_exe2lsu <= 3'b101);
        mem_op  = is_load || (St_cntr_exe2lsu != 2'b00);
        is_byte = is_load ? (Ld_cntr_exe2lsu == 3'b001 || Ld_cntr_exe2lsu == 3'b100)
                          : (St_cntr_exe2lsu == 2'b01);
        is_half = is_load ? (Ld_cntr_exe2lsu == 3'b010 || Ld_cntr_exe2lsu == 3'b101)
                          : (St_cntr_exe2lsu == 2'b10);
        is_word = !is_byte && !is_half;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = mem_op && ((is_half && alu_result[0]) || (is_word && alu_result[1:0] != 2'b00));
        off  = alu_result[1:0];
`else
        // Misaligned halfwords/words silently round down to their natural boundary.
        trap = 1'b0;
        off  = is_half ? {alu_result[1], 1'b0} : (is_word ? 2'b00 : alu_result[1:0]);
`endif
        if (is_load)      be = 4'b1111;
        else if (is_byte) be = 4'b0001 << off;
        else if (is_half) be = 4'b0011 << off;
        else              be = 4'b1111;
        if (is_load)      wdata = '0;
        else if (is_byte) wdata = {4{Rd2_exe2lsu[7:0]}};
        else if (is_half) wdata = {2{Rd2_exe2lsu[15:0]}};
        else              wdata = Rd2_exe2lsu;
    end

    always_comb begin
        lane_b = dmem_rdata[{lat_off, 3'b000} +: 8];
        lane_h = dmem_rdata[{lat_off[1], 4'b0000} +: 16];
        case (lat_ld)
            3'b001:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b010:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'd0, lane_b};
            3'b101:  load_val = {16'd0, lane_h};
            default: load_val = dmem_rdata;
        endcase
    end

    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        lsu_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !trap) begin
                    state_n   = WAIT;
                    lsu_stall = 1'b1;
                end
            end
            WAIT: begin
                lsu_stall = 1'b1;
                if (dmem_ready || timeout_hit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            wb_data    <= '0;
            wb_regw    <= 1'b0;
            wb_addr    <= '0;
            bus_err    <= 1'b0;
            wait_cnt   <= '0;
            lat_ld     <= '0;
            lat_off    <= '0;
            lat_mtr    <= '0;
            lat_regw   <= 1'b0;
            lat_load   <= 1'b0;
            lat_wr     <= '0;
            lat_addr   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (trap) begin
`ifdef LSU_MISALIGN_TRAP_EN
                        misalign <= 1'b1;
`endif
                        wb_regw <= 1'b0;
                    end else if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= !is_load;
                        dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
                        dmem_be    <= be;
                        dmem_wdata <= wdata;
                        lat_ld     <= is_load ? Ld_cntr_exe2lsu : 3'b000;
                        lat_off    <= off;
                        lat_mtr    <= Memtoreg_exe2lsu;
                        lat_regw   <= RegW_exe2lsu;
                        lat_load   <= is_load;
                        lat_wr     <= wr_addr_exe2lsu;
                        lat_addr   <= alu_result;
                        wb_regw    <= 1'b0;
                        wait_cnt   <= '0;
                    end else begin
                        wb_data <= alu_result;
                        wb_regw <= RegW_exe2lsu;
                        wb_addr <= wr_addr_exe2lsu;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        wb_regw  <= lat_regw && lat_load;
                        wb_addr  <= lat_wr;
                        wb_data  <= (lat_mtr == 2'b01) ? load_val : lat_addr;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        wb_regw  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef LSU_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized and directed checks of lsu_stage against a byte-lane
// arithmetic reference model; honours LSU_MISALIGN_TRAP_EN when the build defines it.
module tb_lsu_stage;
    localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, Rd2_exe2lsu, dmem_rdata;
    logic [1:0]  Memtoreg_exe2lsu, St_cntr_exe2lsu;
    logic [2:0]  Ld_cntr_exe2lsu;
    logic        RegW_exe2lsu, dmem_ready;
    logic [4:0]  wr_addr_exe2lsu;
    logic        dmem_req, dmem_we, wb_regw, lsu_stall, bus_err, misalign;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_addr;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    lsu_stage #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .Rd2_exe2lsu(Rd2_exe2lsu),
        .Memtoreg_exe2lsu(Memtoreg_exe2lsu), .Ld_cntr_exe2lsu(Ld_cntr_exe2lsu),
        .St_cntr_exe2lsu(St_cntr_exe2lsu), .RegW_exe2lsu(RegW_exe2lsu),
        .wr_addr_exe2lsu(wr_addr_exe2lsu), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .wb_data(wb_data),
        .wb_regw(wb_regw), .wb_addr(wb_addr), .lsu_stall(lsu_stall),
        .bus_err(bus_err), .misalign(misalign)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget (%0d vectors)", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: access size in bytes, lane arithmetic on 64-bit values
    function automatic bit m_is_load(input logic [2:0] ld);
        return ld >= 3'd1 && ld <= 3'd5;
    endfunction

    function automatic int m_size(input logic [2:0] ld, input logic [1:0] st);
        if (m_is_load(ld)) return (ld == 3'd1 || ld == 3'd4) ? 1 : (ld == 3'd2 || ld == 3'd5) ? 2 : 4;
        return (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
    endfunction

    function automatic int m_offset(input logic [31:0] addr, input int size);
        return int'(addr[1:0]) / size * size;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr);
        int size = m_size(ld, st);
        logic [63:0] m;
        if (m_is_load(ld)) return 4'hF;
        m = ((64'd1 << size) - 64'd1) << m_offset(addr, size);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] rd2);
        logic [63:0] mask = (64'd1 << (8 * size)) - 64'd1;
        logic [63:0] repl = (size == 1) ? 64'h01010101 : (size == 2) ? 64'h00010001 : 64'd1;
        logic [63:0] v = ({32'd0, rd2} & mask) * repl;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ld, input logic [31:0] addr, input logic [31:0] rdata);
        int size = m_size(ld, 2'd0);
        logic [63:0] v = ({32'd0, rdata} >> (8 * m_offset(addr, size))) & ((64'd1 << (8 * size)) - 64'd1);
        if ((ld == 3'd1 || ld == 3'd2) && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    // drivers
    task automatic drive_nop();
        alu_result       = $urandom;
        Rd2_exe2lsu      = $urandom;
        Memtoreg_exe2lsu = 2'($urandom_range(0, 3));
        Ld_cntr_exe2lsu  = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(6, 7)) : 3'd0;
        St_cntr_exe2lsu  = 2'd0;
        RegW_exe2lsu     = 1'($urandom_range(0, 1));
        wr_addr_exe2lsu  = 5'($urandom_range(0, 31));
    endtask

    task automatic do_alu(input logic [31:0] a, input logic regw, input logic [4:0] wr, input logic [2:0] ld);
        @(negedge clk);
        drive_nop();
        alu_result = a; RegW_exe2lsu = regw; wr_addr_exe2lsu = wr; Ld_cntr_exe2lsu = ld;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1 check("alu_stall_comb", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        check("alu_wb_data", wb_data, a);
        check("alu_wb_regw", 32'(wb_regw), 32'(regw));
        check("alu_wb_addr", 32'(wb_addr), 32'(wr));
        check("alu_stall", 32'(lsu_stall), 32'd0);
        check("alu_no_req", 32'(dmem_req), 32'd0);
        dmem_ready = 1'b0;
    endtask

    task automatic do_mem(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                          input logic [31:0] rd2, input logic [1:0] mtr, input logic regw,
                          input logic [4:0] wr, input logic [31:0] rdata, input int wait_cyc);
        bit ld_op;
        int size;
        bit trapped;
        logic [31:0] exp_wb;
        ld_op   = m_is_load(ld);
        size    = m_size(ld, st);
        trapped = TRAP && (int'(a[1:0]) % size != 0);
        @(negedge clk);
        alu_result = a; Rd2_exe2lsu = rd2; Memtoreg_exe2lsu = mtr; Ld_cntr_exe2lsu = ld;
        St_cntr_exe2lsu = st; RegW_exe2lsu = regw; wr_addr_exe2lsu = wr;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1 check("issue_stall_comb", 32'(lsu_stall), trapped ? 32'd0 : 32'd1);
        @(negedge clk);
        if (trapped) begin
            check("trap_misalign", 32'(misalign), 32'd1);
            check("trap_no_req", 32'(dmem_req), 32'd0);
            check("trap_wb_regw", 32'(wb_regw), 32'd0);
            check("trap_stall", 32'(lsu_stall), 32'd0);
            drive_nop();
            dmem_ready = 1'b0;
            @(negedge clk);
            check("trap_pulse_end", 32'(misalign), 32'd0);
            return;
        end
        check("issue_req", 32'(dmem_req), 32'd1);
        check("issue_we", 32'(dmem_we), ld_op ? 32'd0 : 32'd1);
        check("issue_addr", dmem_addr, a & ~32'd3);
        check("issue_be", 32'(dmem_be), 32'(m_be(ld, st, a)));
        if (!ld_op) check("issue_wdata", dmem_wdata, m_wdata(size, rd2));
        check("issue_wb_regw", 32'(wb_regw), 32'd0);
        check("issue_misalign", 32'(misalign), 32'd0);
        exp_wb = (mtr == 2'b01 && ld_op) ? m_load(ld, a, rdata) : a;
        exp_q.push_back(exp_wb);
        drive_nop();
        for (int c = 0; c < TO; c++) begin
            dmem_ready = (c == wait_cyc);
            dmem_rdata = (c == wait_cyc) ? rdata : $urandom;
            @(negedge clk);
            if (c == wait_cyc) begin
                check("done_req", 32'(dmem_req), 32'd0);
                check("done_bus_err", 32'(bus_err), 32'd0);
                check("done_wb_regw", 32'(wb_regw), 32'(regw && ld_op));
                check("done_wb_addr", 32'(wb_addr), 32'(wr));
                if (ld_op || mtr != 2'b01) check("done_wb_data", wb_data, exp_q.pop_front());
                else void'(exp_q.pop_front());
                check("done_stall", 32'(lsu_stall), 32'd0);
                break;
            end else if (c == TO - 1) begin
                void'(exp_q.pop_front());
                check("to_bus_err", 32'(bus_err), 32'd1);
                check("to_req", 32'(dmem_req), 32'd0);
                check("to_wb_regw", 32'(wb_regw), 32'd0);
                check("to_stall", 32'(lsu_stall), 32'd0);
                dmem_ready = 1'b0;
                @(negedge clk);
                check("to_pulse_end", 32'(bus_err), 32'd0);
            end else begin
                check("wait_req", 32'(dmem_req), 32'd1);
                check("wait_addr", dmem_addr, a & ~32'd3);
                check("wait_stall", 32'(lsu_stall), 32'd1);
                check("wait_bus_err", 32'(bus_err), 32'd0);
            end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_we"}, 32'(dmem_we), 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_be"}, 32'(dmem_be), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_wb_regw"}, 32'(wb_regw), 32'd0);
        check({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
        check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
        check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        alu_result = 32'h0000_0200; Ld_cntr_exe2lsu = 3'd3; St_cntr_exe2lsu = 2'd0;
        Memtoreg_exe2lsu = 2'b01; RegW_exe2lsu = 1'b1; wr_addr_exe2lsu = 5'd12;
        @(negedge clk);
        check("rstw_req", 32'(dmem_req), 32'd1);
        drive_nop();
        Ld_cntr_exe2lsu = 3'd0; RegW_exe2lsu = 1'b0;
        @(negedge clk);
        rst = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_all_zero("rstw");
        rst = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        check("rstw_after_regw", 32'(wb_regw), 32'd0);
        check("rstw_after_req", 32'(dmem_req), 32'd0);
        check("rstw_after_bus_err", 32'(bus_err), 32'd0);
    endtask

    // main sequence
    initial begin
        rst = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        drive_nop();
        Ld_cntr_exe2lsu = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        do_alu(32'h0000_1234, 1'b1, 5'd5, 3'd0);
        do_alu(32'hCAFE_0001, 1'b1, 5'd31, 3'd6);
        do_alu(32'h0BAD_F00D, 1'b0, 5'd1, 3'd7);
        do_mem(3'd0, 2'd1, 32'h0000_0103, 32'h0000_00AB, 2'b00, 1'b1, 5'd7, $urandom, 3);
        do_mem(3'd1, 2'd0, 32'h0000_0102, $urandom, 2'b01, 1'b1, 5'd9, 32'h0080_0000, 1);
        do_mem(3'd4, 2'd0, 32'h0000_0102, $urandom, 2'b01, 1'b1, 5'd9, 32'h0080_0000, 1);
        do_mem(3'd2, 2'd3, 32'h0000_0206, $urandom, 2'b01, 1'b1, 5'd4, 32'h8001_7FFF, 0);
        do_mem(3'd5, 2'd0, 32'h0000_0206, $urandom, 2'b01, 1'b1, 5'd4, 32'h8001_7FFF, 2);
        do_mem(3'd0, 2'd2, 32'h0000_0302, 32'h1234_5678, 2'b00, 1'b1, 5'd2, $urandom, 0);
        do_mem(3'd0, 2'd3, 32'h0000_0400, 32'hDEAD_BEEF, 2'b00, 1'b0, 5'd2, $urandom, 1);
        do_mem(3'd3, 2'd0, 32'h0000_0040, $urandom, 2'b01, 1'b1, 5'd6, $urandom, TO);
        do_mem(3'd3, 2'd0, 32'h0000_0044, $urandom, 2'b01, 1'b1, 5'd6, 32'h1357_9BDF, TO - 1);
        do_mem(3'd3, 2'd0, 32'h0000_0048, $urandom, 2'b10, 1'b1, 5'd8, $urandom, 0);
        reset_mid_wait();
        do_mem(3'd3, 2'd0, 32'h0000_0101, $urandom, 2'b01, 1'b1, 5'd3, 32'hCAFE_BABE, 0);
        do_mem(3'd2, 2'd0, 32'h0000_0103, $urandom, 2'b01, 1'b1, 5'd3, 32'h9ABC_1234, 0);
        do_mem(3'd0, 2'd2, 32'h0000_0105, 32'h0000_BEEF, 2'b00, 1'b1, 5'd3, $urandom, 0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                do_alu($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 2) == 0) ? 3'($urandom_range(6, 7)) : 3'd0);
            end else begin
                int w;
                logic [2:0] ld;
                logic [1:0] st;
                w  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 4);
                ld = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 5)) : 3'd0;
                st = (ld == 3'd0) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
                do_mem(ld, st, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), $urandom, w);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
